csi_line_unpacker: RTL

Downstream stage of the CSI-2 receiver's packet protocol stage. Captures the 32-bit RAW8 payload words the receiver emits under `rec_data` into a two-bank (ping-pong) line buffer. Replays each complete line as a one-byte-per-cycle pixel stream with valid/ready handshake, start-of-frame/line/end-of-line markers and a line counter. Flags short lines and buffer overflow as sticky errors.

---
 rtl/csi_line_unpacker_if.sv | 27 ++
 rtl/csi_line_unpacker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/csi_line_unpacker_if.sv
// csi_line_unpacker_if
//   Pixel stream between the line unpacker and its consumer.
//   master (producer): drives pix_o, pix_valid, pix_sof, pix_sol, pix_eol,
//                      line_cnt; samples pix_ready.
//   slave  (consumer): the mirror image.
//   A pixel moves on every cycle with pix_valid && pix_ready.
interface csi_line_unpacker_if #(
  parameter int LC_W = 9
);
  logic [7:0]      pix_o;
  logic            pix_valid;
  logic            pix_ready;
  logic            pix_sof;
  logic            pix_sol;
  logic            pix_eol;
  logic [LC_W-1:0] line_cnt;

  modport master (
    output pix_o, pix_valid, pix_sof, pix_sol, pix_eol, line_cnt,
    input  pix_ready
  );

  modport slave (
    input  pix_o, pix_valid, pix_sof, pix_sol, pix_eol, line_cnt,
    output pix_ready
  );
endinterface

// File: rtl/csi_line_unpacker.sv
// csi_line_unpacker
//   Captures 32-bit RAW8 payload words from the CSI-2 packet stage into a
//   ping-pong line buffer and replays each complete line one byte per cycle.
//   Ports:
//     mipi_clk_8   sole clock (receiver ram_clk domain)
//     reset        async, active low
//     rec_data     payload word strobe; falling edge ends the line packet
//     data_i       payload word, pixel order [7:0],[15:8],[23:16],[31:24]
//     frame_start  1-cycle pulse on frame-start short packet
//     pix          pixel stream (master side of csi_line_unpacker_if)
//     line_err     sticky: a line ended with a word count != LINE_WORDS
//     ovf_err      sticky: a line arrived while both banks were full
module csi_line_unpacker #(
  parameter int LINE_WORDS = 160,
  parameter int MAX_LINES  = 480
) (
  input  logic                 mipi_clk_8,
  input  logic                 reset,
  input  logic                 rec_data,
  input  logic [31:0]          data_i,
  input  logic                 frame_start,
  csi_line_unpacker_if.master  pix,
  output logic                 line_err,
  output logic                 ovf_err
);

  localparam int WA_W = $clog2(LINE_WORDS + 1);
  localparam int RA_W = $clog2(LINE_WORDS);
  localparam int LC_W = $clog2(MAX_LINES);
  localparam logic [WA_W-1:0] WA_END  = WA_W'(LINE_WORDS);
  localparam logic [RA_W-1:0] RA_LAST = RA_W'(LINE_WORDS - 1);
  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(MAX_LINES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} rd_state_t;

  logic [31:0] mem [2][LINE_WORDS];

  // write side
  logic            rec_d, wr_bank, sof_pend;
  logic            drop_q;   // line rejected at its start: no free bank
  logic            skip_q;   // rest of line abandoned by frame_start
  logic            bad_q;    // line overran LINE_WORDS
  logic [WA_W-1:0] wr_addr;
  logic [1:0]      full, sof_tag, full_set, full_clr;

  // read side
  rd_state_t       state_q, state_d;
  logic            rd_bank;
  logic [RA_W-1:0] rd_w, rd_addr;
  logic [1:0]      rd_byte;
  logic [3:0][7:0] cur_word;
  logic [31:0]     nxt_word, rd_word;
  logic [LC_W-1:0] line_cnt_q;

  logic rise, fall, streaming, hs, first_pix, last_pix, release_bank;
  logic full_wr_eff, drop_now, wr_en, commit, short_line;

  always_comb begin
    rise         = rec_data & ~rec_d;
    fall         = ~rec_data & rec_d;
    streaming    = (state_q == S_STREAM);
    hs           = streaming & pix.pix_ready;
    first_pix    = (rd_w == '0) && (rd_byte == 2'd0);
    last_pix     = (rd_w == RA_LAST) && (rd_byte == 2'd3);
    release_bank = hs & last_pix;
    // A bank the reader frees this very cycle counts as free for a new line.
    full_wr_eff  = full[wr_bank] & ~(release_bank & (rd_bank == wr_bank));
    drop_now     = rise ? full_wr_eff : drop_q;
    wr_en        = rec_data & ~frame_start & ~drop_now & ~skip_q & (wr_addr < WA_END);
    commit       = fall & ~frame_start & ~drop_q & ~skip_q & ~bad_q & (wr_addr == WA_END);
    short_line   = fall & ~frame_start & ~drop_q & ~skip_q & ~commit;
    full_set     = {commit & wr_bank, commit & ~wr_bank};
    full_clr     = {release_bank & rd_bank, release_bank & ~rd_bank};
  end

  // line buffer storage, no reset
  always_ff @(posedge mipi_clk_8) begin
    if (wr_en) mem[wr_bank][wr_addr[RA_W-1:0]] <= data_i;
  end

  assign rd_word = mem[rd_bank][rd_addr];

  // write control and bank ownership
  always_ff @(posedge mipi_clk_8 or negedge reset) begin
    if (!reset) begin
      rec_d    <= 1'b0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      drop_q   <= 1'b0;
      skip_q   <= 1'b0;
      bad_q    <= 1'b0;
      sof_pend <= 1'b0;
      full     <= 2'b00;
      sof_tag  <= 2'b00;
      line_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      rec_d <= rec_data;
      full  <= (full | full_set) & ~full_clr;
      if (frame_start) begin
        // abort any partial line; if still in its packet, ignore the rest
        wr_addr  <= '0;
        skip_q   <= rec_data;
        drop_q   <= 1'b0;
        bad_q    <= 1'b0;
        sof_pend <= 1'b1;
      end else if (fall) begin
        wr_addr <= '0;
        skip_q  <= 1'b0;
        drop_q  <= 1'b0;
        bad_q   <= 1'b0;
        if (commit) begin
          sof_tag[wr_bank] <= sof_pend;
          wr_bank          <= ~wr_bank;
          sof_pend         <= 1'b0;
        end
        if (short_line) line_err <= 1'b1;
      end else if (rec_data) begin
        if (rise) begin
          drop_q <= full_wr_eff;
          if (full_wr_eff) ovf_err <= 1'b1;
        end
        if (wr_en)                  wr_addr <= wr_addr + 1'b1;
        else if (!drop_now && !skip_q) bad_q <= 1'b1;  // word past line end
      end
    end
  end

  // read FSM: next state and read address
  always_comb begin
    state_d = state_q;
    rd_addr = '0;
    case (state_q)
      S_IDLE:  if (full[rd_bank]) state_d = S_FETCH;
      S_FETCH: state_d = S_STREAM;
      S_STREAM: begin
        // prefetch the following word while bytes of the current one drain
        rd_addr = (rd_w == RA_LAST) ? '0 : rd_w + 1'b1;
        if (release_bank) state_d = full[~rd_bank] ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mipi_clk_8 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rd_bank    <= 1'b0;
      rd_w       <= '0;
      rd_byte    <= 2'd0;
      cur_word   <= '0;
      nxt_word   <= '0;
      line_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: begin
          cur_word <= rd_word;
          rd_w     <= '0;
          rd_byte  <= 2'd0;
          if (sof_tag[rd_bank]) line_cnt_q <= '0;
        end
        S_STREAM: begin
          nxt_word <= rd_word;
          if (hs) begin
            rd_byte <= rd_byte + 1'b1;
            if (rd_byte == 2'd3) begin
              cur_word <= nxt_word;
              rd_w     <= last_pix ? '0 : rd_w + 1'b1;
            end
            if (last_pix) begin
              rd_bank <= ~rd_bank;
              if (line_cnt_q != LC_MAX) line_cnt_q <= line_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix.pix_valid = streaming;
  assign pix.pix_o     = cur_word[rd_byte];
  assign pix.pix_sol   = streaming & first_pix;
  assign pix.pix_sof   = streaming & first_pix & sof_tag[rd_bank];
  assign pix.pix_eol   = streaming & last_pix;
  assign pix.line_cnt  = line_cnt_q;

endmodule
